// File: rtl/telem_pkt_parser.sv
// Telemetry frame parser: AA 55 + three 12-bit fields (hi/lo byte pairs) from a UART byte stream.
// Define TELEM_CHKSUM_EN to require a trailing inverted-sum checksum byte after the payload.
module telem_pkt_parser #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rdy,
   output logic        pkt_vld,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] torque,
   output logic        pkt_err,
   output logic [15:0] pkt_cnt,
   output logic [1:0]  state_dbg
);

`ifdef TELEM_CHKSUM_EN
   typedef enum logic [1:0] {IDLE, HDR2, PAYLD, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, HDR2, PAYLD} state_t;
`endif

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   // Handshake: a byte is taken on every edge where rx_rdy=1; clr_rdy mirrors rx_rdy so the
   // receiver drops the byte immediately and nothing is ever consumed twice.
   assign clr_rdy = rx_rdy;

   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [11:0]   sh_batt_q, sh_batt_d, sh_curr_q, sh_curr_d, sh_torque_q, sh_torque_d;
   logic [11:0]   batt_q, batt_d, curr_q, curr_d, torque_q, torque_d;
   logic          pkt_vld_q, pkt_vld_d, pkt_err_q, pkt_err_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;
   logic          good;
`ifdef TELEM_CHKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      sh_batt_d   = sh_batt_q;
      sh_curr_d   = sh_curr_q;
      sh_torque_d = sh_torque_q;
      batt_d      = batt_q;
      curr_d      = curr_q;
      torque_d    = torque_q;
      pkt_vld_d   = 1'b0;
      pkt_err_d   = 1'b0;
      pkt_cnt_d   = pkt_cnt_q;
      good        = 1'b0;
`ifdef TELEM_CHKSUM_EN
      sum_d       = sum_q;
`endif
      if (rx_rdy) begin
         tmo_d = '0;
         case (state_q)
            IDLE: if (rx_data == 8'hAA) state_d = HDR2;
            HDR2: begin
               if (rx_data == 8'h55) begin
                  state_d = PAYLD;
                  idx_d   = 3'd0;
`ifdef TELEM_CHKSUM_EN
                  sum_d   = 8'h00;
`endif
               end else if (rx_data != 8'hAA) begin
                  state_d = IDLE;
               end
            end
            PAYLD: begin
               // Even indices are hi bytes; only their low nibble is meaningful.
               if (!idx_q[0] && (rx_data[7:4] != 4'h0)) begin
                  pkt_err_d   = 1'b1;
                  state_d     = IDLE;
                  sh_batt_d   = '0;
                  sh_curr_d   = '0;
                  sh_torque_d = '0;
               end else begin
                  case (idx_q)
                     3'd0:    sh_batt_d[11:8]   = rx_data[3:0];
                     3'd1:    sh_batt_d[7:0]    = rx_data;
                     3'd2:    sh_curr_d[11:8]   = rx_data[3:0];
                     3'd3:    sh_curr_d[7:0]    = rx_data;
                     3'd4:    sh_torque_d[11:8] = rx_data[3:0];
                     default: sh_torque_d[7:0]  = rx_data;
                  endcase
`ifdef TELEM_CHKSUM_EN
                  sum_d = sum_q + rx_data;
                  if (idx_q == 3'd5) state_d = CHK;
                  else               idx_d   = idx_q + 3'd1;
`else
                  if (idx_q == 3'd5) good  = 1'b1;
                  else               idx_d = idx_q + 3'd1;
`endif
               end
            end
`ifdef TELEM_CHKSUM_EN
            CHK: begin
               state_d = IDLE;
               if (rx_data == ~sum_q) good      = 1'b1;
               else                   pkt_err_d = 1'b1;
            end
`endif
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         // A waiting byte always beats the timeout since this branch only runs without rx_rdy.
         if (tmo_q == TMO_LAST) begin
            state_d     = IDLE;
            pkt_err_d   = 1'b1;
            tmo_d       = '0;
            sh_batt_d   = '0;
            sh_curr_d   = '0;
            sh_torque_d = '0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
      // pkt_cnt updates on the same edge pkt_vld rises, so it is current while pkt_vld is high.
      if (good) begin
         state_d   = IDLE;
         batt_d    = sh_batt_d;
         curr_d    = sh_curr_d;
         torque_d  = sh_torque_d;
         pkt_vld_d = 1'b1;
         if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         tmo_q       <= '0;
         sh_batt_q   <= '0;
         sh_curr_q   <= '0;
         sh_torque_q <= '0;
         batt_q      <= '0;
         curr_q      <= '0;
         torque_q    <= '0;
         pkt_vld_q   <= 1'b0;
         pkt_err_q   <= 1'b0;
         pkt_cnt_q   <= '0;
`ifdef TELEM_CHKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         sh_batt_q   <= sh_batt_d;
         sh_curr_q   <= sh_curr_d;
         sh_torque_q <= sh_torque_d;
         batt_q      <= batt_d;
         curr_q      <= curr_d;
         torque_q    <= torque_d;
         pkt_vld_q   <= pkt_vld_d;
         pkt_err_q   <= pkt_err_d;
         pkt_cnt_q   <= pkt_cnt_d;
`ifdef TELEM_CHKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign pkt_vld   = pkt_vld_q;
   assign pkt_err   = pkt_err_q;
   assign batt      = batt_q;
   assign curr      = curr_q;
   assign torque    = torque_q;
   assign pkt_cnt   = pkt_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_telem_pkt_parser.sv
// Bench for telem_pkt_parser: directed frames plus random byte streams checked by a queue-based
// reference model; honours TELEM_CHKSUM_EN the same way the design does.
module tb_telem_pkt_parser;
   localparam int T = 40;
   localparam int W = 53;

   logic        clk = 1'b0;
   logic        rst_n, rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rdy, pkt_vld, pkt_err;
   logic [11:0] batt, curr, torque;
   logic [15:0] pkt_cnt;
   logic [1:0]  state_dbg;

   telem_pkt_parser #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
      .pkt_vld(pkt_vld), .batt(batt), .curr(curr), .torque(torque), .pkt_err(pkt_err),
      .pkt_cnt(pkt_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];

   // Reference model: hunting / seen-AA / collecting payload bytes into a queue.
   int          phase = 0;
   int          run = 0;
   logic [7:0]  pay[$];
   logic [11:0] m_batt = 0, m_curr = 0, m_torque = 0;
   logic [15:0] m_cnt = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_evt(bit err);
      exp_q.push_back({err, m_batt, m_curr, m_torque, m_cnt});
   endtask

   task automatic commit();
      m_batt   = {pay[0][3:0], pay[1]};
      m_curr   = {pay[2][3:0], pay[3]};
      m_torque = {pay[4][3:0], pay[5]};
      if (m_cnt != 16'hFFFF) m_cnt++;
      push_evt(1'b0);
   endtask

   function automatic logic [7:0] pay_ck();
      logic [7:0] s = 8'h00;
      foreach (pay[i]) s += pay[i];
      return ~s;
   endfunction

   task automatic model_byte(logic [7:0] b);
      run = 0;
      if (phase == 0) begin
         if (b == 8'hAA) phase = 1;
      end else if (phase == 1) begin
         if (b == 8'h55) begin
            phase = 2;
            pay.delete();
         end else if (b != 8'hAA) phase = 0;
      end else if (pay.size() < 6) begin
         if ((pay.size() % 2 == 0) && (b[7:4] != 4'h0)) begin
            push_evt(1'b1);
            phase = 0;
         end else begin
            pay.push_back(b);
`ifndef TELEM_CHKSUM_EN
            if (pay.size() == 6) begin
               commit();
               phase = 0;
            end
`endif
         end
      end else begin
         if (b == pay_ck()) commit();
         else               push_evt(1'b1);
         phase = 0;
      end
   endtask

   task automatic model_gap(int n);
      run += n;
      if (phase != 0 && run >= T) begin
         push_evt(1'b1);
         phase = 0;
      end
   endtask

   task automatic model_reset();
      phase = 0; run = 0; pay.delete();
      m_batt = 0; m_curr = 0; m_torque = 0; m_cnt = 0;
   endtask

   task automatic drive(bit rdy, logic [7:0] d);
      @(posedge clk);
      #2;
      rx_rdy  = rdy;
      rx_data = d;
   endtask

   task automatic send(logic [7:0] b);
      model_byte(b);
      drive(1'b1, b);
   endtask

   task automatic idle(int n);
      model_gap(n);
      repeat (n) drive(1'b0, 8'($urandom));
   endtask

   // ck < 0 sends the correct checksum; gap_at selects one payload byte preceded by gap_len idles.
   task automatic send_frame(logic [47:0] p, int ck, int gapmax, int gap_at, int gap_len);
      logic [7:0] s = 8'h00;
      logic [7:0] b;
      send(8'hAA);
      send(8'h55);
      for (int i = 0; i < 6; i++) begin
         b = p[47 - 8*i -: 8];
         s += b;
         if (i == gap_at) idle(gap_len);
         else             idle($urandom_range(0, gapmax));
         send(b);
      end
`ifdef TELEM_CHKSUM_EN
      send((ck < 0) ? ~s : 8'(ck));
`endif
   endtask

   function automatic logic [47:0] rand_payload();
      logic [47:0] p = '0;
      for (int i = 0; i < 6; i++)
         p = {p[39:0], (i % 2 == 0) ? {4'h0, 4'($urandom)} : 8'($urandom)};
      return p;
   endfunction

   task automatic check_outputs(string tag, logic [11:0] b, logic [11:0] c, logic [11:0] t,
                                logic [15:0] n);
      check({tag, "_batt"}, batt, b);
      check({tag, "_curr"}, curr, c);
      check({tag, "_torque"}, torque, t);
      check({tag, "_cnt"}, pkt_cnt, n);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      rx_rdy  = 1'b1;
      rx_data = 8'hAA;
      model_reset();
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check_outputs("rst", 12'h0, 12'h0, 12'h0, 16'h0);
         check("rst_vld", pkt_vld, 0);
         check("rst_err", pkt_err, 0);
         check("rst_clr_rdy", clr_rdy, 1);
      end
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      rx_rdy = 1'b0;
   endtask

   // Monitor: handshake mirror every cycle, and each pulse pops one expected event.
   always @(negedge clk) begin
      logic [W-1:0] e;
      check("clr_follows_rdy", clr_rdy, rx_rdy);
      if (pkt_vld === 1'b1 || pkt_err === 1'b1) begin
         check("vld_err_exclusive", pkt_vld & pkt_err, 0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got vld=%0b err=%0b expected none at %0t",
                     pkt_vld, pkt_err, $time);
         end else begin
            e = exp_q.pop_front();
            check("evt_is_err", pkt_err, e[52]);
            check("evt_batt", batt, e[51:40]);
            check("evt_curr", curr, e[39:28]);
            check("evt_torque", torque, e[27:16]);
            check("evt_cnt", pkt_cnt, e[15:0]);
         end
      end
   end

   initial begin
      #500000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int r, k;
      logic [47:0] p;
      rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs("reset", 12'h0, 12'h0, 12'h0, 16'h0);
      check("reset_vld", pkt_vld, 0);
      check("reset_err", pkt_err, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Basic good frame.
      send_frame(48'h0B_BB_01_23_0B_CD, -1, 0, -1, 0);
      idle(3);
      @(negedge clk);
      check_outputs("frame1", 12'hBBB, 12'h123, 12'hBCD, 16'd1);

      // Leading junk and a repeated AA before 55.
      send(8'h12);
      send(8'hAA);
      send_frame(48'h08_88_00_40_07_89, -1, 0, -1, 0);
      idle(3);
      @(negedge clk);
      check_outputs("resync", 12'h888, 12'h040, 12'h789, 16'd2);

      // Bad hi nibble in curr_hi.
      send_frame(48'h0B_BB_31_23_0B_CD, -1, 0, -1, 0);
      idle(3);
      @(negedge clk);
      check_outputs("hi_err", 12'h888, 12'h040, 12'h789, 16'd2);

      // Timeout mid-packet, then a byte arriving exactly as the timeout would fire.
      send(8'hAA); send(8'h55); send(8'h0B);
      idle(T);
      send_frame(48'h01_02_03_04_05_06, -1, 0, -1, 0);
      send_frame(48'h0F_FF_0E_EE_0D_DD, -1, 0, 3, T - 1);
      idle(3);
      @(negedge clk);
      check_outputs("tmo_edge", 12'hFFF, 12'hEEE, 12'hDDD, 16'd4);

      // Reset after four payload bytes.
      send(8'hAA); send(8'h55); send(8'h01); send(8'h11); send(8'h02); send(8'h22);
      do_reset();
      send_frame(48'h03_33_04_44_05_55, -1, 0, -1, 0);
      idle(3);
      @(negedge clk);
      check_outputs("post_rst", 12'h333, 12'h444, 12'h555, 16'd1);

`ifdef TELEM_CHKSUM_EN
      send_frame(48'h0B_BB_01_23_0B_CD, 0, 0, -1, 0);
      send_frame(48'h0B_BB_01_23_0B_CD, -1, 0, -1, 0);
      idle(3);
`endif

      // Random mix of good, corrupt, truncated and junk traffic, mostly back to back.
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 9);
         p = rand_payload();
         case (r)
            5: begin
               k = 2 * $urandom_range(0, 2);
               p[47 - 8*k -: 4] = 4'($urandom_range(1, 15));
               send_frame(p, -1, 1, -1, 0);
            end
            6: send(8'($urandom));
            7: begin
               send(8'hAA); send(8'h55);
               k = $urandom_range(0, 5);
               for (int j = 0; j < k; j++) send(p[47 - 8*j -: 8]);
               idle(T + $urandom_range(0, 4));
            end
            8: send_frame(p, -1, 0, $urandom_range(0, 5), T - 1 - $urandom_range(0, 1));
            9: send_frame(p, $urandom_range(0, 255), 0, -1, 0);
            default: send_frame(p, -1, 1, -1, 0);
         endcase
         idle($urandom_range(0, 2));
      end

      idle(T + 5);
      for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
